// File: rtl/pid_pkg.sv
// Shared definitions for the PID duty controller: datapath widths, parameter
// defaults and the controller FSM state encoding.
package pid_pkg;

    localparam int unsigned DATA_W       = 24;               // positions, error, integral, duty
    localparam int unsigned GAIN_W       = 16;               // Q8.8 gains
    localparam int unsigned ACC_W        = 42;               // product accumulator
    localparam int unsigned PROD_W       = DATA_W + GAIN_W;  // single multiplier result

    localparam int unsigned SHIFT_DEF    = 8;
    localparam int unsigned DUTY_MAX_DEF = 1600;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        INT,
        MP,
        MI,
        MD,
        SAT
    } state_e;

endpackage : pid_pkg

// File: rtl/signed_saturate.sv
// Combinational signed clamp. The output is limited to [-limit_i, +limit_i]
// and additionally to the representable OUT_W-bit signed range, so an
// all-ones limit yields a plain width saturation.
//   in_i    : signed value to clamp (IN_W bits)
//   limit_i : unsigned clamp magnitude (LIM_W bits)
//   out_o   : clamped signed result (OUT_W bits)
module signed_saturate #(
    parameter int unsigned IN_W  = 25,
    parameter int unsigned OUT_W = 24,
    parameter int unsigned LIM_W = 24
) (
    input  logic signed [IN_W-1:0]  in_i,
    input  logic        [LIM_W-1:0] limit_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam int unsigned MAX_IL = (IN_W > LIM_W) ? IN_W : LIM_W;
    localparam int unsigned CW     = ((MAX_IL > OUT_W) ? MAX_IL : OUT_W) + 2;

    logic signed [CW-1:0] x;
    logic signed [CW-1:0] lim_p;
    logic signed [CW-1:0] lim_n;
    logic signed [CW-1:0] out_max;
    logic signed [CW-1:0] out_min;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    logic signed [CW-1:0] r;
    logic                 sat_unused;

    // Work at a width wide enough that no intermediate can overflow.
    always_comb begin
        x       = {{(CW-IN_W){in_i[IN_W-1]}}, in_i};
        lim_p   = {{(CW-LIM_W){1'b0}}, limit_i};
        lim_n   = -lim_p;
        out_max = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        out_min = ~out_max;
        hi      = (lim_p < out_max) ? lim_p : out_max;
        lo      = (lim_n > out_min) ? lim_n : out_min;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
    end

    // Upper bits are known to be sign copies after the clamp.
    assign sat_unused = ^r[CW-1:OUT_W];
    assign out_o      = r[OUT_W-1:0];

endmodule : signed_saturate

// File: rtl/pid_duty_controller.sv
// Sequential PID controller producing a signed PWM duty.
// One update strobe runs a fixed 7-state computation through a single shared
// 24x16 multiplier; the result is registered on duty with a one-cycle valid.
//   clk, reset          : clock and synchronous active-high reset
//   enable              : low forces idle, zero duty, cleared integrator
//   update              : one-cycle strobe starting a computation (ignored when busy)
//   setpoint, position  : signed 24-bit target and measurement
//   Kp, Ki, Kd          : signed Q8.8 gains
//   integral_limit      : unsigned integrator clamp magnitude
//   duty, valid, busy   : registered signed duty, update pulse, computation active
module pid_duty_controller
    import pid_pkg::*;
#(
    parameter int unsigned DUTY_MAX = DUTY_MAX_DEF,
    parameter int unsigned SHIFT    = SHIFT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] setpoint,
    input  logic signed [DATA_W-1:0] position,
    input  logic signed [GAIN_W-1:0] Kp,
    input  logic signed [GAIN_W-1:0] Ki,
    input  logic signed [GAIN_W-1:0] Kd,
    input  logic        [DATA_W-1:0] integral_limit,
    output logic signed [DATA_W-1:0] duty,
    output logic                     valid,
    output logic                     busy
);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] sp_q, sp_d;
    logic signed [DATA_W-1:0] pos_q, pos_d;
    logic signed [DATA_W-1:0] err_q, err_d;
    logic signed [DATA_W-1:0] integ_q, integ_d;
    logic signed [DATA_W-1:0] deriv_q, deriv_d;
    logic signed [DATA_W-1:0] prev_q, prev_d;
    logic signed [DATA_W-1:0] duty_q, duty_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;

    logic signed [DATA_W:0]   err_raw;
    logic signed [DATA_W:0]   int_sum;
    logic signed [DATA_W:0]   deriv_raw;
    logic signed [DATA_W-1:0] err_sat;
    logic signed [DATA_W-1:0] int_sat;
    logic signed [DATA_W-1:0] deriv_sat;
    logic signed [DATA_W-1:0] duty_sat;
    logic signed [ACC_W-1:0]  acc_shift;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [GAIN_W-1:0] mul_b;
    logic signed [PROD_W-1:0] product;

    localparam logic [DATA_W-1:0] FULL_RANGE = {DATA_W{1'b1}};

    // 25-bit intermediates; saturated back to 24 bits below.
    assign err_raw   = (DATA_W+1)'(sp_q)    - (DATA_W+1)'(pos_q);
    assign int_sum   = (DATA_W+1)'(integ_q) + (DATA_W+1)'(err_q);
    assign deriv_raw = (DATA_W+1)'(err_q)   - (DATA_W+1)'(prev_q);
    assign acc_shift = acc_q >>> SHIFT;

    signed_saturate #(.IN_W(DATA_W+1), .OUT_W(DATA_W), .LIM_W(DATA_W)) u_sat_err (
        .in_i(err_raw), .limit_i(FULL_RANGE), .out_o(err_sat)
    );

    signed_saturate #(.IN_W(DATA_W+1), .OUT_W(DATA_W), .LIM_W(DATA_W)) u_sat_int (
        .in_i(int_sum), .limit_i(integral_limit), .out_o(int_sat)
    );

    signed_saturate #(.IN_W(DATA_W+1), .OUT_W(DATA_W), .LIM_W(DATA_W)) u_sat_deriv (
        .in_i(deriv_raw), .limit_i(FULL_RANGE), .out_o(deriv_sat)
    );

    signed_saturate #(.IN_W(ACC_W), .OUT_W(DATA_W), .LIM_W(DATA_W)) u_sat_duty (
        .in_i(acc_shift), .limit_i(DATA_W'(DUTY_MAX)), .out_o(duty_sat)
    );

    // Operand select for the one shared multiplier.
    always_comb begin
        mul_a = err_q;
        mul_b = Kp;
        case (state_q)
            MI:      begin mul_a = integ_q; mul_b = Ki; end
            MD:      begin mul_a = deriv_q; mul_b = Kd; end
            default: begin mul_a = err_q;   mul_b = Kp; end
        endcase
    end

    assign product = PROD_W'(mul_a) * PROD_W'(mul_b);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        pos_d   = pos_q;
        err_d   = err_q;
        integ_d = integ_q;
        deriv_d = deriv_q;
        prev_d  = prev_q;
        duty_d  = duty_q;
        acc_d   = acc_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (update) begin
                    sp_d    = setpoint;
                    pos_d   = position;
                    state_d = ERR;
                end
            end
            ERR: begin
                err_d   = err_sat;
                acc_d   = '0;
                state_d = INT;
            end
            INT: begin
                integ_d = int_sat;
                deriv_d = deriv_sat;
                state_d = MP;
            end
            MP: begin
                acc_d   = acc_q + ACC_W'(product);
                state_d = MI;
            end
            MI: begin
                acc_d   = acc_q + ACC_W'(product);
                state_d = MD;
            end
            MD: begin
                acc_d   = acc_q + ACC_W'(product);
                state_d = SAT;
            end
            SAT: begin
                duty_d  = duty_sat;
                prev_d  = err_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything, including an in-flight result.
        if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
            integ_d = '0;
            prev_d  = '0;
            acc_d   = '0;
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= '0;
            pos_q   <= '0;
            err_q   <= '0;
            integ_q <= '0;
            deriv_q <= '0;
            prev_q  <= '0;
            duty_q  <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
            integ_q <= integ_d;
            deriv_q <= deriv_d;
            prev_q  <= prev_d;
            duty_q  <= duty_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign duty  = duty_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule : pid_duty_controller

// File: tb/tb_pid_duty_controller.sv
// Self-checking bench for pid_duty_controller with a behavioural PID model.
module tb_pid_duty_controller;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               update;
    logic signed [23:0] setpoint;
    logic signed [23:0] position;
    logic signed [15:0] Kp, Ki, Kd;
    logic        [23:0] integral_limit;
    logic signed [23:0] duty;
    logic               valid;
    logic               busy;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;

    longint m_integ;
    longint m_prev;

    pid_duty_controller dut (
        .clk(clk), .reset(reset), .enable(enable), .update(update),
        .setpoint(setpoint), .position(position),
        .Kp(Kp), .Ki(Ki), .Kd(Kd), .integral_limit(integral_limit),
        .duty(duty), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint clampl(longint x, longint lo, longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        m_integ = 0;
        m_prev  = 0;
    endtask

    task automatic model_step(output longint d);
        longint err, der, acc, lim, lo, hi;
        err     = clampl(longint'(setpoint) - longint'(position), MINV, MAXV);
        lim     = longint'(integral_limit);
        hi      = (lim < MAXV) ? lim : MAXV;
        lo      = (-lim > MINV) ? -lim : MINV;
        m_integ = clampl(m_integ + err, lo, hi);
        der     = clampl(err - m_prev, MINV, MAXV);
        acc     = longint'(Kp) * err + longint'(Ki) * m_integ + longint'(Kd) * der;
        d       = clampl(acc >>> 8, -64'sd1600, 64'sd1600);
        m_prev  = err;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic set_gains(input int p, input int i, input int d, input int lim);
        Kp = 16'(p); Ki = 16'(i); Kd = 16'(d);
        integral_limit = 24'(lim);
    endtask

    // Pulse update and wait (bounded) for valid; returns what was observed.
    task automatic run_update(output bit seen, output int lat, output int nbusy,
                              output logic signed [23:0] d);
        seen = 1'b0; lat = 0; nbusy = 0; d = '0;
        update = 1'b1;
        tick();
        update = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (valid) begin
                seen = 1'b1; lat = k; d = duty;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (duty !== 24'sd0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
        n_cmp++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    endtask

    task automatic test_proportional();
        bit seen; int lat, nb; logic signed [23:0] d; longint exp_d;
        do_reset();
        set_gains(256, 0, 0, 1000);
        setpoint = 24'sd100; position = 24'sd0;
        run_update(seen, lat, nb, d);
        model_step(exp_d);
        n_cmp++; if (!seen)      begin n_fail++; $display("FAIL prop_valid: got none want pulse"); end
        n_cmp++; if (lat != 7)   begin n_fail++; $display("FAIL prop_latency: got %0d want 7", lat); end
        n_cmp++; if (nb != 6)    begin n_fail++; $display("FAIL prop_busy_cycles: got %0d want 6", nb); end
        n_cmp++; if (d !== 24'(exp_d)) begin n_fail++; $display("FAIL prop_duty: got %0d want %0d", d, exp_d); end
        tick();
        n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prop_valid_width: got %0b want 0", valid); end
        n_cmp++; if (duty !== 24'(exp_d)) begin n_fail++; $display("FAIL prop_hold: got %0d want %0d", duty, exp_d); end
    endtask

    task automatic test_saturation();
        bit seen; int lat, nb; logic signed [23:0] d; longint exp_d;
        int sps[2]  = '{2000, -2500};
        int poss[2] = '{-3000, 2500};
        do_reset();
        set_gains(256, 0, 0, 1000);
        for (int i = 0; i < 2; i++) begin
            setpoint = 24'(sps[i]); position = 24'(poss[i]);
            run_update(seen, lat, nb, d);
            model_step(exp_d);
            n_cmp++; if (!seen || d !== 24'(exp_d)) begin
                n_fail++; $display("FAIL sat_duty[%0d]: got %0d (valid=%0b) want %0d", i, d, seen, exp_d);
            end
        end
    endtask

    task automatic test_antiwindup();
        bit seen; int lat, nb; logic signed [23:0] d; longint exp_d;
        do_reset();
        set_gains(0, 256, 0, 300);
        setpoint = 24'sd200; position = 24'sd0;
        for (int i = 0; i < 3; i++) begin
            run_update(seen, lat, nb, d);
            model_step(exp_d);
            n_cmp++; if (!seen || d !== 24'(exp_d)) begin
                n_fail++; $display("FAIL windup_duty[%0d]: got %0d (valid=%0b) want %0d", i, d, seen, exp_d);
            end
        end
    endtask

    task automatic test_derivative();
        bit seen; int lat, nb; logic signed [23:0] d; longint exp_d;
        int errs[2] = '{10, 50};
        do_reset();
        set_gains(0, 0, 256, 1000);
        position = 24'sd0;
        for (int i = 0; i < 2; i++) begin
            setpoint = 24'(errs[i]);
            run_update(seen, lat, nb, d);
            model_step(exp_d);
            n_cmp++; if (!seen || d !== 24'(exp_d)) begin
                n_fail++; $display("FAIL deriv_duty[%0d]: got %0d (valid=%0b) want %0d", i, d, seen, exp_d);
            end
        end
    endtask

    task automatic test_abort();
        bit seen; int lat, nb, nvalid; logic signed [23:0] d; longint exp_d;
        do_reset();
        set_gains(256, 0, 0, 1000);
        setpoint = 24'sd100; position = 24'sd0;
        // Second strobe while busy must be dropped.
        update = 1'b1;
        tick();
        nvalid = 0; d = '0;
        for (int k = 1; k <= 14; k++) begin
            update = (k == 2);
            if (k == 2) setpoint = 24'sd777;
            if (valid) begin nvalid++; d = duty; end
            tick();
        end
        update = 1'b0;
        setpoint = 24'sd100;
        model_step(exp_d);
        n_cmp++; if (nvalid != 1) begin n_fail++; $display("FAIL abort_ignore_count: got %0d want 1", nvalid); end
        n_cmp++; if (d !== 24'(exp_d)) begin n_fail++; $display("FAIL abort_ignore_duty: got %0d want %0d", d, exp_d); end

        // Reset in the third cycle of a computation.
        do_reset();
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid) nvalid++;
            tick();
        end
        n_cmp++; if (nvalid != 0)    begin n_fail++; $display("FAIL abort_reset_valid: got %0d pulses want 0", nvalid); end
        n_cmp++; if (duty !== 24'sd0) begin n_fail++; $display("FAIL abort_reset_duty: got %0d want 0", duty); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL abort_reset_busy: got %0b want 0", busy); end
        set_gains(0, 256, 0, 1000);
        setpoint = 24'sd200; position = 24'sd0;
        run_update(seen, lat, nb, d);
        model_step(exp_d);
        n_cmp++; if (!seen || d !== 24'(exp_d)) begin
            n_fail++; $display("FAIL abort_after_reset_duty: got %0d (valid=%0b) want %0d", d, seen, exp_d);
        end
    endtask

    task automatic test_enable();
        bit seen; int lat, nb, nvalid; logic signed [23:0] d; longint exp_d;
        do_reset();
        set_gains(256, 256, 0, 100000);
        setpoint = 24'sd300; position = 24'sd0;
        run_update(seen, lat, nb, d);
        model_step(exp_d);
        n_cmp++; if (!seen || d !== 24'(exp_d)) begin
            n_fail++; $display("FAIL enable_pre_duty: got %0d (valid=%0b) want %0d", d, seen, exp_d);
        end
        // Drop enable mid-computation.
        update = 1'b1;
        tick();
        update = 1'b0;
        tick();
        enable = 1'b0;
        model_reset();
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid) nvalid++;
            update = (k == 4);
        end
        update = 1'b0;
        n_cmp++; if (nvalid != 0)    begin n_fail++; $display("FAIL enable_low_valid: got %0d pulses want 0", nvalid); end
        n_cmp++; if (duty !== 24'sd0) begin n_fail++; $display("FAIL enable_low_duty: got %0d want 0", duty); end
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL enable_low_busy: got %0b want 0", busy); end
        enable = 1'b1;
        tick();
        set_gains(0, 0, 256, 100000);
        setpoint = 24'sd50;
        run_update(seen, lat, nb, d);
        model_step(exp_d);
        n_cmp++; if (!seen || d !== 24'(exp_d)) begin
            n_fail++; $display("FAIL enable_prev_cleared: got %0d (valid=%0b) want %0d", d, seen, exp_d);
        end
    endtask

    task automatic test_random();
        bit seen; int lat, nb, gap; logic signed [23:0] d; longint exp_d;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            set_gains(int'($urandom_range(0, 2047)) - 1024,
                      int'($urandom_range(0, 511)) - 256,
                      int'($urandom_range(0, 2047)) - 1024,
                      ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : int'($urandom_range(0, 200000)));
            if ($urandom_range(0, 5) == 0) begin
                setpoint = 24'($urandom);
                position = 24'($urandom);
            end else begin
                setpoint = 24'(int'($urandom_range(0, 10000)) - 5000);
                position = 24'(int'($urandom_range(0, 10000)) - 5000);
            end
            run_update(seen, lat, nb, d);
            model_step(exp_d);
            n_cmp++; if (!seen || lat != 7) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d (valid=%0b) want 7", i, lat, seen);
            end
            n_cmp++; if (d !== 24'(exp_d)) begin
                n_fail++; $display("FAIL rand_duty[%0d]: got %0d want %0d", i, d, exp_d);
            end
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                n_cmp++; if (valid !== 1'b0 || duty !== 24'(exp_d)) begin
                    n_fail++; $display("FAIL rand_hold[%0d]: got duty %0d valid %0b want %0d/0", i, duty, valid, exp_d);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; update = 1'b0;
        setpoint = '0; position = '0;
        Kp = '0; Ki = '0; Kd = '0; integral_limit = '0;
        model_reset();
        tick();
        test_reset();
        test_proportional();
        test_saturation();
        test_antiwindup();
        test_derivative();
        test_abort();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pid_duty_controller
